// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Opcode and state enums live together, so the opcode members carry an OP_ infix.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_OP_NOP   = 4'd0,
    MDU_OP_MUL   = 4'd1,
    MDU_OP_MULW  = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_REM   = 4'd5,
    MDU_OP_REMU  = 4'd6,
    MDU_OP_DIVW  = 4'd7,
    MDU_OP_DIVUW = 4'd8,
    MDU_OP_REMW  = 4'd9,
    MDU_OP_REMUW = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE} mdu_state_t;

  localparam int MDU_ITER_D = 64;
  localparam int MDU_ITER_W = 32;
  localparam int MDU_CNT_W  = 7;

  function automatic logic op_is_mul(input mdu_op_t op);
    return op inside {MDU_OP_MUL, MDU_OP_MULW};
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return op inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_REM, MDU_OP_REMU,
                      MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction

  function automatic logic op_is_w(input mdu_op_t op);
    return op inside {MDU_OP_MULW, MDU_OP_DIVW, MDU_OP_DIVUW, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return op inside {MDU_OP_DIV, MDU_OP_REM, MDU_OP_DIVW, MDU_OP_REMW};
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op inside {MDU_OP_REM, MDU_OP_REMU, MDU_OP_REMW, MDU_OP_REMUW};
  endfunction

endpackage

// File: rtl/mdu_divcore.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
// quot/rem expose the result of the iteration being performed this cycle.
module mdu_divcore
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [XLEN-1:0]      dividend,
  input  logic [XLEN-1:0]      divisor,
  input  logic [MDU_CNT_W-1:0] iters,
  output logic                 last,
  output logic [XLEN-1:0]      quot,
  output logic [XLEN-1:0]      rem
);

  logic [XLEN-1:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]        rem_sh, diff;
  logic                 fits;

  // Dividend bits shift out of quo_q's MSB while quotient bits shift into its LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    fits   = ~diff[XLEN];
    quot   = {quo_q[XLEN-2:0], fits};
    rem    = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    last   = (cnt_q == MDU_CNT_W'(1));

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = iters;
    end else if (cnt_q != '0) begin
      rem_d = rem;
      quo_d = quot;
      cnt_d = cnt_q - MDU_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit: request/response handshake, shift-add multiply,
// special-case resolution and sign correction around the restoring divide core.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  mdu_op_t         req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int CW = MDU_CNT_W;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
    return w ? sext32(v[31:0]) : v;
  endfunction

  mdu_state_t      state_q, state_d;
  logic            req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            w_q, w_d, isrem_q, isrem_d, negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]   mcnt_q, mcnt_d;

  logic            is_w, sgn, a_neg, b_neg, div_zero, div_ovf, accept;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_ext, q_raw, q_fin, r_fin, mul_step;
  logic            div_start, div_last;
  logic [XLEN-1:0] div_dividend, div_divisor, div_quot, div_rem;
  logic [CW-1:0]   div_iters;

  mdu_divcore #(.XLEN(XLEN)) u_divcore (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (flush),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .iters    (div_iters),
    .last     (div_last),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_comb begin
    is_w     = op_is_w(req_op);
    sgn      = op_is_signed(req_op);
    a_ext    = is_w ? (sgn ? sext32(req_a[31:0]) : zext32(req_a[31:0])) : req_a;
    b_ext    = is_w ? (sgn ? sext32(req_b[31:0]) : zext32(req_b[31:0])) : req_b;
    a_neg    = sgn & a_ext[XLEN-1];
    b_neg    = sgn & b_ext[XLEN-1];
    abs_a    = a_neg ? -a_ext : a_ext;
    abs_b    = b_neg ? -b_ext : b_ext;
    min_ext  = is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = sgn && (b_ext == {XLEN{1'b1}}) && (a_ext == min_ext);
    accept   = (state_q == MDU_IDLE) && req_valid && !flush;

    // W dividends are left-aligned so 32 iterations consume exactly their 32 bits.
    div_start    = 1'b0;
    div_dividend = is_w ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
    div_divisor  = abs_b;
    div_iters    = is_w ? CW'(MDU_ITER_W) : CW'(MDU_ITER_D);

    q_raw    = w_q ? zext32(div_quot[31:0]) : div_quot;
    q_fin    = negq_q ? -q_raw : q_raw;
    r_fin    = negr_q ? -div_rem : div_rem;
    mul_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    state_d     = state_q;
    resp_data_d = resp_data_q;
    w_d         = w_q;
    isrem_d     = isrem_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    mcnt_d      = mcnt_q;

    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          w_d     = is_w;
          isrem_d = op_is_rem(req_op);
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          if (op_is_mul(req_op)) begin
            if (FAST_MUL) begin
              state_d     = MDU_DONE;
              resp_data_d = fix_w(req_a * req_b, is_w);
            end else begin
              state_d  = MDU_MUL;
              acc_d    = '0;
              mcand_d  = is_w ? zext32(req_a[31:0]) : req_a;
              mplier_d = is_w ? zext32(req_b[31:0]) : req_b;
              mcnt_d   = div_iters;
            end
          end else if (op_is_div(req_op)) begin
            if (div_zero) begin
              state_d     = MDU_DONE;
              resp_data_d = fix_w(op_is_rem(req_op) ? a_ext : {XLEN{1'b1}}, is_w);
            end else if (div_ovf) begin
              state_d     = MDU_DONE;
              resp_data_d = fix_w(op_is_rem(req_op) ? '0 : a_ext, is_w);
            end else begin
              state_d   = MDU_DIV;
              div_start = 1'b1;
            end
          end else begin
            state_d     = MDU_DONE;
            resp_data_d = '0;
          end
        end
      end
      MDU_MUL: begin
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q - CW'(1);
        if (mcnt_q == CW'(1)) begin
          state_d     = MDU_DONE;
          resp_data_d = fix_w(mul_step, w_q);
        end
      end
      MDU_DIV: begin
        if (div_last) begin
          state_d     = MDU_DONE;
          resp_data_d = fix_w(isrem_q ? r_fin : q_fin, w_q);
        end
      end
      MDU_DONE: begin
        if (resp_ready) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush) state_d = MDU_IDLE;

    req_ready_d  = (state_d == MDU_IDLE);
    resp_valid_d = (state_d == MDU_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= MDU_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      w_q          <= 1'b0;
      isrem_q      <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      w_q          <= w_d;
      isrem_q      <= isrem_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      mcnt_q       <= mcnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed vector bench for mdu_iterative: result values, latencies, handshake,
// flush and reset behaviour against hand-computed expectations.
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, resp_valid, resp_ready;
  mdu_op_t     req_op;
  logic [63:0] req_a, req_b, resp_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    mdu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  mdu_iterative #(.XLEN(64), .FAST_MUL(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", nm, act, exp);
    end
  endtask

  task automatic issue(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    check("ready_at_issue", req_ready, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 64'hDEAD_BEEF_DEAD_BEEF;
    req_b = 64'h0123_4567_89AB_CDEF;
  endtask

  task automatic wait_resp(output int lat, output bit ready_hi);
    lat = 1; ready_hi = 1'b0;
    while (!resp_valid && lat < 200) begin
      if (req_ready) ready_hi = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (req_ready) ready_hi = 1'b1;
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({nm, "_valid_drop"}, resp_valid, 64'd0);
    check({nm, "_ready_rise"}, req_ready, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    bit rh;
    issue(v.op, v.a, v.b);
    wait_resp(lat, rh);
    check({nm, "_data"}, resp_data, v.exp);
    check({nm, "_latency"}, 64'(lat), 64'(v.lat));
    check({nm, "_ready_while_busy"}, 64'(rh), 64'd0);
    handshake(nm);
  endtask

  initial begin
    int lat;
    bit rh;
    int seen;

    vecs[0]  = '{MDU_OP_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{MDU_OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[2]  = '{MDU_OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{MDU_OP_DIVU,  64'd100, 64'd7, 64'd14, 65};
    vecs[4]  = '{MDU_OP_REMU,  64'd100, 64'd7, 64'd2, 65};
    vecs[5]  = '{MDU_OP_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{MDU_OP_REMU,  64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{MDU_OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{MDU_OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{MDU_OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[10] = '{MDU_OP_MULW,  64'h0000_0001_0000_0002, 64'd3, 64'd6, 33};
    vecs[11] = '{MDU_OP_NOP,   64'd123, 64'd456, 64'd0, 1};
    vecs[12] = '{MDU_OP_REMW,  64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[13] = '{MDU_OP_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 1};
    vecs[14] = '{MDU_OP_REMUW, 64'hFFFF_0000_FFFF_FFFF, 64'd16, 64'd15, 33};
    vecs[15] = '{MDU_OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65};
    vecs[16] = '{MDU_OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65};
    vecs[17] = '{MDU_OP_DIVW,  64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[18] = '{MDU_OP_REMW,  64'hABCD_0000_8000_0007, 64'hFFFF_FFFF_0000_0000,
                 64'hFFFF_FFFF_8000_0007, 1};

    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = MDU_OP_NOP; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 64'd1);
    check("reset_resp_valid", resp_valid, 64'd0);
    check("reset_resp_data", resp_data, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response held for 10 cycles with resp_ready low.
    issue(MDU_OP_DIVU, 64'd100, 64'd7);
    wait_resp(lat, rh);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d_valid", i), resp_valid, 64'd1);
      check($sformatf("hold%0d_data", i), resp_data, 64'd14);
      @(posedge clk); #1;
    end
    handshake("hold");

    // Flush in the middle of a divide.
    issue(MDU_OP_DIV, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_valid", resp_valid, 64'd0);
    check("flush_div_ready", req_ready, 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("flush_div_no_resp", 64'(seen), 64'd0);

    // Flush concurrent with a request in IDLE drops the request.
    @(negedge clk);
    req_op = MDU_OP_NOP; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("flush_idle_dropped", 64'(seen), 64'd0);
    check("flush_idle_ready", req_ready, 64'd1);

    // Flush concurrent with the DONE handshake.
    issue(MDU_OP_DIVU, 64'd9, 64'd0);
    wait_resp(lat, rh);
    check("flush_done_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    resp_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; flush = 1'b0;
    check("flush_done_valid", resp_valid, 64'd0);
    check("flush_done_ready", req_ready, 64'd1);

    run_vec('{MDU_OP_MUL, 64'd3, 64'd4, 64'd12, 65}, "mul_after_flush");

    // Reset in the middle of a multiply.
    issue(MDU_OP_MUL, 64'd5, 64'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_req_ready", req_ready, 64'd1);
    check("midreset_resp_valid", resp_valid, 64'd0);
    check("midreset_resp_data", resp_data, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[4], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
